// File: rtl/clock_tick_gen.sv
// Multi-channel clock-enable generator: per-channel tick strobe,
// divided square wave and activity flag, all in the CLK domain.
module clock_tick_gen #(
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 4
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    EN,
   input  logic                    SYNC_CLR,
   input  logic [NUM_CH-1:0]       DIV_LD,
   input  logic [NUM_CH*CNT_W-1:0] DIV_VAL,
   output logic [NUM_CH-1:0]       TICK,
   output logic [NUM_CH-1:0]       CLK_DIV,
   output logic [NUM_CH-1:0]       ACTIVE
);

   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] div_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] div_n;
      logic [CNT_W-1:0] cnt_n;
      logic [CNT_W-1:0] last;
      logic             tick_q;
      logic             cd_q;
      logic             act_q;
      logic             tick_n;
      logic             cd_n;
      logic             run;
      logic             wrap;

      always_comb begin
         div_n  = DIV_LD[c] ? DIV_VAL[c*CNT_W +: CNT_W] : div_q;
         last   = div_q - ONE;
         run    = EN && (div_q != '0);
         wrap   = (cnt_q == last);
         cnt_n  = cnt_q;
         tick_n = 1'b0;
         cd_n   = cd_q;
         if (SYNC_CLR || DIV_LD[c]) begin
            cnt_n = '0;
            cd_n  = 1'b0;
         end else if (run) begin
            cnt_n  = wrap ? '0 : cnt_q + ONE;
            tick_n = wrap;
            // high for the last floor(div/2) counts of each period
            cd_n   = (cnt_n >= (div_q - (div_q >> 1)));
         end else if (div_q == '0) begin
            cd_n = 1'b0;
         end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            div_q  <= DEF;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            cd_q   <= 1'b0;
            act_q  <= 1'b0;
         end else begin
            div_q  <= div_n;
            cnt_q  <= cnt_n;
            tick_q <= tick_n;
            cd_q   <= cd_n;
            act_q  <= EN && (div_n != '0);
         end
      end

      assign TICK[c]    = tick_q;
      assign CLK_DIV[c] = cd_q;
      assign ACTIVE[c]  = act_q;
   end

endmodule

// File: tb/tb_clock_tick_gen.sv
// Scoreboard bench for clock_tick_gen: stimulus pushes expected
// outputs from an elapsed-count model, a monitor pops and compares.
module tb_clock_tick_gen;

   localparam int NC = 2;
   localparam int CW = 4;
   localparam int DD = 4;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          EN = 1'b0;
   logic          SYNC_CLR = 1'b0;
   logic [NC-1:0] DIV_LD = '0;
   logic [NC*CW-1:0] DIV_VAL = '0;
   logic [NC-1:0] TICK;
   logic [NC-1:0] CLK_DIV;
   logic [NC-1:0] ACTIVE;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [3*NC-1:0] expq[$];

   // model: divisor and enabled cycles counted since last restart
   int mdiv[NC];
   int el[NC];

   clock_tick_gen #(
      .NUM_CH (NC),
      .CNT_W  (CW),
      .DEF_DIV(DD)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .EN      (EN),
      .SYNC_CLR(SYNC_CLR),
      .DIV_LD  (DIV_LD),
      .DIV_VAL (DIV_VAL),
      .TICK    (TICK),
      .CLK_DIV (CLK_DIV),
      .ACTIVE  (ACTIVE)
   );

   always #5 CLK = ~CLK;

   function automatic void model_reset();
      for (int c = 0; c < NC; c++) begin
         mdiv[c] = DD;
         el[c]   = 0;
      end
   endfunction

   function automatic logic [3*NC-1:0] model_step(
      input logic e, input logic clr,
      input logic [NC-1:0] ld, input logic [NC*CW-1:0] v);
      logic [NC-1:0] t, d, a;
      for (int c = 0; c < NC; c++) begin
         int ph;
         t[c] = 1'b0;
         if (clr || ld[c]) begin
            if (ld[c]) mdiv[c] = int'(v[c*CW +: CW]);
            el[c] = 0;
            d[c]  = 1'b0;
         end else begin
            if (e && mdiv[c] != 0) begin
               el[c]++;
               t[c] = (el[c] % mdiv[c]) == 0;
            end
            ph   = (mdiv[c] != 0) ? el[c] % mdiv[c] : 0;
            d[c] = (mdiv[c] != 0) && (ph >= mdiv[c] - mdiv[c] / 2);
         end
         a[c] = e && (mdiv[c] != 0);
      end
      return {t, d, a};
   endfunction

   task automatic step(input logic e, input logic clr,
                       input logic [NC-1:0] ld,
                       input logic [NC*CW-1:0] v);
      @(negedge CLK);
      RST_N    = 1'b1;
      EN       = e;
      SYNC_CLR = clr;
      DIV_LD   = ld;
      DIV_VAL  = v;
      expq.push_back(model_step(e, clr, ld, v));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0);
   endtask

   task automatic rst_pulse();
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      tests++;
      if ({TICK, CLK_DIV, ACTIVE} != '0) begin
         fails++;
         $display("FAIL async_reset got %b want %b",
                  {TICK, CLK_DIV, ACTIVE}, 6'b0);
      end
      model_reset();
      expq.push_back('0);
   endtask

   always @(posedge CLK) begin
      logic [3*NC-1:0] got;
      logic [3*NC-1:0] want;
      #1;
      cyc++;
      if (expq.size() > 0) begin
         want = expq.pop_front();
         got  = {TICK, CLK_DIV, ACTIVE};
         tests++;
         if (got !== want) begin
            fails++;
            $display("FAIL cyc%0d {tick,clkdiv,active} got %b want %b",
                     cyc, got, want);
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge CLK);
      tests++;
      if ({TICK, CLK_DIV, ACTIVE} != '0) begin
         fails++;
         $display("FAIL reset_state got %b want 0",
                  {TICK, CLK_DIV, ACTIVE});
      end
      // default divisor 4 on both channels
      run(13);
      // reload ch0 with 3 mid-period
      rst_pulse();
      run(2);
      step(1'b1, 1'b0, 2'b01, {4'd0, 4'd3});
      run(10);
      // divisors 1 and 0
      step(1'b1, 1'b0, 2'b11, {4'd0, 4'd1});
      run(5);
      // EN low for 5 cycles at cnt=1, div=4
      step(1'b1, 1'b0, 2'b11, {4'd4, 4'd4});
      run(1);
      repeat (5) step(1'b0, 1'b0, '0, '0);
      run(6);
      // clear with a simultaneous load on ch1
      run(2);
      step(1'b1, 1'b1, 2'b10, {4'd6, 4'd9});
      run(14);
      // all-ones divisor, then async reset mid-period
      step(1'b1, 1'b0, 2'b01, {4'd0, 4'd15});
      run(62);
      rst_pulse();
      run(9);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic          e, clr;
         logic [NC-1:0] ld;
         logic [NC*CW-1:0] v;
         e   = ($urandom_range(0, 99) < 85);
         clr = ($urandom_range(0, 99) < 2);
         for (int c = 0; c < NC; c++)
            ld[c] = ($urandom_range(0, 99) < 4);
         v = NC*CW'($urandom);
         if (i % 150 == 75) rst_pulse();
         step(e, clr, ld, v);
      end
      repeat (3) @(negedge CLK);
      tests++;
      if (expq.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d want 0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
